// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the execute stage.
//   alu_op_e - 3-bit ALU operation encoding
//   cond_e   - 4-bit ARM-style condition code
//   flags_t  - packed NZCV flags (n at bit 3)
//   ctrl_t   - control bundle captured into EX/MEM, CTRL_BUBBLE is its squashed value
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MOV  = 3'b101,
    ALU_MUL  = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0,
                                    mem_write: 1'b0, pc_src: 1'b0};

  localparam flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/cond_unit.sv
// cond_unit: combinational evaluation of an ARM-style condition code.
//   cond_i    in  4   condition code (cond_e encoding)
//   flags_i   in  4   current NZCV flags
//   cond_ex_o out 1   1 when the instruction should execute
// Code 0xF has no defined meaning here and is treated as "always".
module cond_unit
  import exec_pkg::*;
(
  input  logic [3:0] cond_i,
  input  flags_t     flags_i,
  output logic       cond_ex_o
);

  logic ge_s;

  assign ge_s = (flags_i.n == flags_i.v);

  // Decode the condition against the flags
  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: cond_ex_o = flags_i.z;
      COND_NE: cond_ex_o = ~flags_i.z;
      COND_CS: cond_ex_o = flags_i.c;
      COND_CC: cond_ex_o = ~flags_i.c;
      COND_MI: cond_ex_o = flags_i.n;
      COND_PL: cond_ex_o = ~flags_i.n;
      COND_VS: cond_ex_o = flags_i.v;
      COND_VC: cond_ex_o = ~flags_i.v;
      COND_HI: cond_ex_o = flags_i.c & ~flags_i.z;
      COND_LS: cond_ex_o = ~flags_i.c | flags_i.z;
      COND_GE: cond_ex_o = ge_s;
      COND_LT: cond_ex_o = ~ge_s;
      COND_GT: cond_ex_o = ~flags_i.z & ge_s;
      COND_LE: cond_ex_o = flags_i.z | ~ge_s;
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_cond_stage.sv
// execute_cond_stage: execute stage of the pipeline. Evaluates the condition
// field against NZCV, runs the ALU, updates the flags register and captures
// the EX/MEM pipeline register. All state changes on the falling clock edge.
//
// Optional feature macro: EXEC_MUL_EN
//   defined   - opcode 110 is a truncated WIDTH x WIDTH multiply
//   undefined - opcode 110 behaves like the reserved opcode (result 0)
//
// Ports:
//   clk, rst (async active-low), stall, flush
//   RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, FlagsWriteE - decoded controls
//   ALUControlE[2:0], CondE[3:0], WA3E[3:0], rd1E, rd2E, ExtImmE [WIDTH-1:0]
//   RegWriteM, MemtoRegM, MemWriteM, PCSrcM - gated controls to memory stage
//   WA3M[3:0], ALUResultM, WriteDataM [WIDTH-1:0], FlagsQ[3:0] (N at bit 3)
module execute_cond_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic             FlagsWriteE,
  input  logic [2:0]       ALUControlE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       WA3E,
  input  logic [WIDTH-1:0] rd1E,
  input  logic [WIDTH-1:0] rd2E,
  input  logic [WIDTH-1:0] ExtImmE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic             PCSrcM,
  output logic [3:0]       WA3M,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       FlagsQ
);

  // Architectural flags and EX/MEM register
  flags_t           flags_q, flags_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [3:0]       wa3_q;
  logic [WIDTH-1:0] alu_result_q;
  logic [WIDTH-1:0] write_data_q;

  // Datapath
  logic             cond_ex_s;
  logic             is_sub_s;
  logic             is_arith_s;
  logic             flag_we_s;
  logic [WIDTH-1:0] src_b_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH:0]   sum_s;
  logic             add_v_s;
  logic [WIDTH-1:0] result_s;

  cond_unit u_cond_unit (
    .cond_i    (CondE),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex_s)
  );

  assign src_b_s = ALUSrcE ? ExtImmE : rd2E;

  // ADD and SUB share one adder: SUB is A + ~B + 1, so the carry out is
  // the "no borrow" flag and the overflow test is identical for both.
  assign is_sub_s   = (ALUControlE == 3'b001);
  assign is_arith_s = (ALUControlE == 3'b000) | is_sub_s;
  assign b_op_s     = is_sub_s ? ~src_b_s : src_b_s;
  assign sum_s      = {1'b0, rd1E} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, is_sub_s};
  assign add_v_s    = (rd1E[WIDTH-1] == b_op_s[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != rd1E[WIDTH-1]);

`ifdef EXEC_MUL_EN
  logic [WIDTH-1:0] mul_s;
  assign mul_s = rd1E * src_b_s;
`endif

  // ALU result selection
  always_comb begin
    result_s = '0;
    case (alu_op_e'(ALUControlE))
      ALU_ADD:  result_s = sum_s[WIDTH-1:0];
      ALU_SUB:  result_s = sum_s[WIDTH-1:0];
      ALU_AND:  result_s = rd1E & src_b_s;
      ALU_ORR:  result_s = rd1E | src_b_s;
      ALU_EOR:  result_s = rd1E ^ src_b_s;
      ALU_MOV:  result_s = src_b_s;
`ifdef EXEC_MUL_EN
      ALU_MUL:  result_s = mul_s;
`else
      ALU_MUL:  result_s = '0;
`endif
      ALU_RSVD: result_s = '0;
      default:  result_s = '0;
    endcase
  end

  // Next flags: N/Z from every op, C/V only from ADD/SUB
  always_comb begin
    flags_d   = flags_q;
    flags_d.n = result_s[WIDTH-1];
    flags_d.z = (result_s == '0);
    if (is_arith_s) begin
      flags_d.c = sum_s[WIDTH];
      flags_d.v = add_v_s;
    end else begin
      flags_d.c = flags_q.c;
      flags_d.v = flags_q.v;
    end
  end

  assign flag_we_s = FlagsWriteE & cond_ex_s & ~stall & ~flush;

  // Control bundle gated by the condition result
  always_comb begin
    ctrl_d            = CTRL_BUBBLE;
    ctrl_d.reg_write  = RegWriteE & cond_ex_s;
    ctrl_d.mem_to_reg = MemtoRegE;
    ctrl_d.mem_write  = MemWriteE & cond_ex_s;
    ctrl_d.pc_src     = BranchE & cond_ex_s;
  end

  // EX/MEM register: flush writes a bubble and wins over stall
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q       <= CTRL_BUBBLE;
      wa3_q        <= 4'h0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else if (flush) begin
      ctrl_q       <= CTRL_BUBBLE;
      wa3_q        <= 4'h0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else if (!stall) begin
      ctrl_q       <= ctrl_d;
      wa3_q        <= WA3E;
      alu_result_q <= result_s;
      write_data_q <= rd2E;
    end
  end

  // Flags register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= FLAGS_RESET;
    end else if (flag_we_s) begin
      flags_q <= flags_d;
    end
  end

  assign RegWriteM  = ctrl_q.reg_write;
  assign MemtoRegM  = ctrl_q.mem_to_reg;
  assign MemWriteM  = ctrl_q.mem_write;
  assign PCSrcM     = ctrl_q.pc_src;
  assign WA3M       = wa3_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign FlagsQ     = flags_q;

endmodule

// File: tb/tb_execute_cond_stage.sv
// tb_execute_cond_stage: directed, self-checking bench for execute_cond_stage.
// State updates on the falling edge; outputs are sampled 1 time unit later.
module tb_execute_cond_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, FlagsWriteE;
  logic [2:0]  ALUControlE;
  logic [3:0]  CondE;
  logic [3:0]  WA3E;
  logic [31:0] rd1E, rd2E, ExtImmE;
  logic        RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  FlagsQ;

  int n_tests = 0;
  int n_fail  = 0;

  execute_cond_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .FlagsWriteE (FlagsWriteE),
    .ALUControlE (ALUControlE),
    .CondE       (CondE),
    .WA3E        (WA3E),
    .rd1E        (rd1E),
    .rd2E        (rd2E),
    .ExtImmE     (ExtImmE),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .PCSrcM      (PCSrcM),
    .WA3M        (WA3M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .FlagsQ      (FlagsQ)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] imm, input logic fw,
                       input logic [3:0] cond, input logic rw, input logic mw,
                       input logic br, input logic [3:0] wa);
    ALUControlE = op;
    rd1E        = a;
    rd2E        = b;
    ALUSrcE     = src;
    ExtImmE     = imm;
    FlagsWriteE = fw;
    CondE       = cond;
    RegWriteE   = rw;
    MemWriteE   = mw;
    BranchE     = br;
    WA3E        = wa;
    MemtoRegE   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Branch every condition code against the current flags, bit i of exp = taken for cond i
  task automatic cond_sweep(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      drive(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'(i), 1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      chk($sformatf("%s_cond%0d", tag, i), {31'h0, PCSrcM}, {31'h0, exp[i]});
    end
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    #3;
    chk("reset_flags", {28'h0, FlagsQ}, 32'h0);
    chk("reset_result", ALUResultM, 32'h0);
    chk("reset_ctrl", {28'h0, RegWriteM, MemtoRegM, MemWriteM, PCSrcM}, 32'h0);
    @(posedge clk);
    rst = 1'b1;

    // SUBS 5-5 -> zero with carry
    drive(3'b001, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h3);
    tick();
    chk("subs55_result", ALUResultM, 32'h0);
    chk("subs55_flags", {28'h0, FlagsQ}, 32'h6);
    chk("subs55_regwrite", {31'h0, RegWriteM}, 32'h1);
    chk("subs55_wa3", {28'h0, WA3M}, 32'h3);
    chk("subs55_wdata", WriteDataM, 32'd5);

    // BEQ taken, target computed with the immediate
    drive(3'b000, 32'h100, 32'h0, 1'b1, 32'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    chk("beq_taken", {31'h0, PCSrcM}, 32'h1);
    chk("beq_target", ALUResultM, 32'h108);

    // SUBS 5-6 -> negative, borrow
    drive(3'b001, 32'd5, 32'd6, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h3);
    tick();
    chk("subs56_result", ALUResultM, 32'hFFFF_FFFF);
    chk("subs56_flags", {28'h0, FlagsQ}, 32'h8);

    drive(3'b000, 32'h100, 32'h0, 1'b1, 32'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    chk("beq_not_taken", {31'h0, PCSrcM}, 32'h0);

    cond_sweep("f1000", 16'hEA9A);

    // SUBS 6-5 -> C=1 Z=0, so HI is taken
    drive(3'b001, 32'd6, 32'd5, 1'b0, 32'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    chk("subs65_flags", {28'h0, FlagsQ}, 32'h2);
    drive(3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    chk("bhi_taken", {31'h0, PCSrcM}, 32'h1);

    // ADDS signed overflow
    drive(3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    chk("adds_ovf_result", ALUResultM, 32'h8000_0000);
    chk("adds_ovf_flags", {28'h0, FlagsQ}, 32'h9);

    cond_sweep("f1001", 16'hD65A);

    // ANDS -> zero, keeps C=0 V=1
    drive(3'b010, 32'hF0, 32'h0F, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h2);
    tick();
    chk("ands_result", ALUResultM, 32'h0);
    chk("ands_flags", {28'h0, FlagsQ}, 32'h5);

    // ADDS with unsigned carry out
    drive(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    chk("adds_carry_result", ALUResultM, 32'h0);
    chk("adds_carry_flags", {28'h0, FlagsQ}, 32'h6);

    cond_sweep("f0110", 16'hE6A5);

    // STRNE with Z=1: fails, but result/WA3/store data still captured
    drive(3'b000, 32'h1000, 32'hDEAD, 1'b1, 32'h4, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h7);
    tick();
    chk("strne_memwrite", {31'h0, MemWriteM}, 32'h0);
    chk("strne_flags", {28'h0, FlagsQ}, 32'h6);
    chk("strne_result", ALUResultM, 32'h1004);
    chk("strne_wa3", {28'h0, WA3M}, 32'h7);
    chk("strne_wdata", WriteDataM, 32'hDEAD);

    // STREQ passes
    drive(3'b000, 32'h2000, 32'hBEEF, 1'b1, 32'h8, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    chk("streq_memwrite", {31'h0, MemWriteM}, 32'h1);

    // ADDS 1+2 then stall for three cycles with changing inputs
    drive(3'b000, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h2);
    tick();
    chk("add12_result", ALUResultM, 32'd3);
    chk("add12_flags", {28'h0, FlagsQ}, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 32'd7 + 32'(i), 32'd9, 1'b0, 32'h0, 1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 4'hB);
      tick();
      chk($sformatf("stall%0d_result", i), ALUResultM, 32'd3);
      chk($sformatf("stall%0d_flags", i), {28'h0, FlagsQ}, 32'h0);
      chk($sformatf("stall%0d_ctrl", i), {28'h0, RegWriteM, MemtoRegM, MemWriteM, PCSrcM}, 32'h8);
      chk($sformatf("stall%0d_wa3", i), {28'h0, WA3M}, 32'h2);
    end

    // flush + stall: bubble, no flag update
    flush = 1'b1;
    drive(3'b001, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 4'h4);
    tick();
    chk("flush_ctrl", {28'h0, RegWriteM, MemtoRegM, MemWriteM, PCSrcM}, 32'h0);
    chk("flush_flags", {28'h0, FlagsQ}, 32'h0);
    chk("flush_result", ALUResultM, 32'h0);
    stall = 1'b0;
    flush = 1'b0;

    // MUL 0x10000 * 0x10001
    drive(3'b110, 32'h1_0000, 32'h1_0001, 1'b0, 32'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 4'h9);
    tick();
`ifdef EXEC_MUL_EN
    chk("mul_result", ALUResultM, 32'h0001_0000);
    chk("mul_flags", {28'h0, FlagsQ}, 32'h0);
`else
    chk("mul_result", ALUResultM, 32'h0);
    chk("mul_flags", {28'h0, FlagsQ}, 32'h4);
`endif
    chk("mul_regwrite", {31'h0, RegWriteM}, 32'h1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b0;
    #1;
    chk("areset_ctrl", {28'h0, RegWriteM, MemtoRegM, MemWriteM, PCSrcM}, 32'h0);
    chk("areset_flags", {28'h0, FlagsQ}, 32'h0);
    chk("areset_wa3", {28'h0, WA3M}, 32'h0);
    chk("areset_wdata", WriteDataM, 32'h0);
    chk("areset_result", ALUResultM, 32'h0);
    #10;
    rst = 1'b1;
    #10;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_cond_stage.md
# execute_cond_stage

Execute stage of the pipelined CPU: consumes the decoded instruction fields held by the ID/EX register, evaluates the ARM-style condition field against the architectural NZCV flags, performs the ALU operation, updates the flags register and captures results into the EX/MEM pipeline register. It sits directly downstream of the ID/EX register and directly upstream of the memory stage. It also produces the registered branch-taken signal to the fetch stage.

## Interface
- `WIDTH`, default 32: datapath width.
- `clk`  in  1  clock; all state updates on the falling edge, matching the rest of the pipeline.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the EX/MEM register and flags.
- `flush`  in  1  squash the instruction currently in E.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `BranchE`, `ALUSrcE`, `FlagsWriteE`  in  1 each  decoded controls.
- `ALUControlE`  in  3  ALU operation.
- `CondE`  in  4  condition code.
- `WA3E`  in  4  destination register.
- `rd1E`, `rd2E`, `ExtImmE`  in  WIDTH  operands and extended immediate.
- `RegWriteM`, `MemtoRegM`, `MemWriteM`  out  1  gated controls to the memory stage.
- `PCSrcM`  out  1  branch taken.
- `WA3M`  out  4  destination register.
- `ALUResultM`, `WriteDataM`  out  WIDTH  ALU result, store data (rd2E).
- `FlagsQ`  out  4  current NZCV (N at bit 3).

## Operation
- SrcB = ALUSrcE ? ExtImmE : rd2E; SrcA = rd1E.
- ALUControl: 000 ADD, 001 SUB (A−B), 010 AND, 011 ORR, 100 EOR, 101 MOV (SrcB), 110 MUL (low WIDTH bits), 111 reserved (result 0).
- Condition codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL, F treated as AL. The condition is evaluated on FlagsQ *before* this instruction's update. The result is CondEx.
- Gating: RegWrite, MemWrite and Branch are ANDed with CondEx. MemtoReg passes through. PCSrcM = BranchE & CondEx.
- Flags are updated only when FlagsWriteE & CondEx & !stall & !flush.
  - N = result[WIDTH−1]; Z = (result == 0).
  - ADD: C = carry out of the WIDTH+1-bit sum; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out (1 = no borrow); V = signed overflow.
  - Logic, MOV and MUL ops keep C and V.
- flush: writes a bubble into EX/MEM (all control outputs 0, data don't-care but driven 0) and suppresses the flag update. flush has priority over stall.
- stall (without flush): all outputs and flags hold.

## Timing
- One-cycle latency: operands valid before the falling edge n appear on the M outputs after edge n.
- Reset (`rst` low, asynchronous): every output is 0 and FlagsQ = 0000. A reset mid-instruction discards it.
- Back-to-back flag producer then consumer: the consumer in the next cycle sees the updated flags; there is no bypass hazard inside the block.
- Conditional instruction that fails: it still occupies a slot. M controls are 0, but ALUResultM and WA3M are still captured.

## Configuration
- `EXEC_MUL_EN`:
  - Defined: opcode 110 is a WIDTH×WIDTH multiply, truncated, and the multiplier is instantiated.
  - Undefined: opcode 110 behaves like 111 (result 0, N=0, Z=1 if flag-writing). No multiplier logic is present.

## Structure
- Package `exec_pkg`:
  - `alu_op_e` (3-bit enum);
  - `cond_e` (4-bit enum);
  - `flags_t` packed struct {n,z,c,v};
  - bubble constant for the control bundle.
- Sub-module `cond_unit`: combinational, takes CondE and flags_t and returns CondEx. The ALU, flags register and EX/MEM register stay in the top module.

## Test plan
- Reset: drive `rst`=0 mid-cycle → all outputs 0 and FlagsQ=0000 immediately, without waiting for a clock.
- SUBS 5−5 with FlagsWriteE=1, CondE=E, then a BEQ-style op (BranchE=1, CondE=0) → FlagsQ=0110 (Z,C); the branch gives PCSrcM=1. Repeat with 5−6 → FlagsQ=1000 and PCSrcM=0.
- ADD 0x7FFFFFFF+1 with flags → ALUResultM=0x80000000, FlagsQ=1001. Then ADD 0xFFFFFFFF+1 → result 0, FlagsQ=0110.
- Conditional store with CondE=1 (NE) while Z=1 → MemWriteM=0, FlagsQ unchanged, ALUResultM still captured.
- stall held 3 cycles while inputs change → outputs and flags constant. Then flush+stall together → bubble written (RegWriteM=MemWriteM=PCSrcM=0) and flags unchanged.
- With `EXEC_MUL_EN`: MUL 0x10000×0x10001 → 0x00010000 (truncated). Without it → 0, and Z=1 if FlagsWriteE.
